ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (XLEN 32, 5-bit register index).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 ex_valid  input  1  EX stage presents a valid instruction this cycle.
REQ-005 ex_result  input  32  ALU/shifter result; effective address for loads/stores.
REQ-006 ex_rs2  input  32  store data source.
REQ-007 ex_rd  input  5  destination register index.
REQ-008 ex_reg_write  input  1  instruction writes rd (non-memory ops and loads).
REQ-009 ex_load, ex_store  input  1 each  memory op type; both high is illegal and SHALL be treated as misaligned.
REQ-010 ex_funct3  input  3  RV32I load/store width code.
REQ-011 flush  input  1  kill the instruction presented by EX this cycle.
REQ-012 ex_stall  output  1  upstream SHALL hold its outputs while high.
REQ-013 dmem_req, dmem_we  output  1 each  memory request; write enable.
REQ-014 dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 dmem_wdata  output  32  lane-replicated store data; dmem_be  output  4  byte enables.
REQ-016 dmem_gnt, dmem_rvalid  input  1 each  request accepted; read data valid.
REQ-017 dmem_rdata  input  32  read word.
REQ-018 wb_valid, wb_reg_write, wb_exc  output  1 each  retire pulse, write-back enable, misalignment exception.
REQ-019 wb_rd  output  5; wb_data  output  32  write-back index and value.

Function
REQ-020 FSM states SHALL be IDLE, REQ, RESP; ex_stall SHALL equal (state != IDLE).
REQ-021 Capture SHALL occur on an edge in IDLE with ex_valid=1 and flush=0; flush=1 or ex_valid=0 in IDLE SHALL capture nothing.
REQ-022 Non-memory op (ex_load=ex_store=0): at capture edge wb_valid<=1, wb_data<=ex_result, wb_rd<=ex_rd, wb_reg_write<=ex_reg_write, wb_exc<=0; state stays IDLE (latency 1).
REQ-023 Misaligned memory op (half with addr[0]=1; word with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 > 010): at capture edge wb_valid<=1, wb_exc<=1, wb_reg_write<=0, wb_data<=ex_result; no dmem_req ever issued.
REQ-024 Aligned memory op: at capture edge address, rs2, rd, funct3, op type SHALL be held internally and state<=REQ; wb_valid<=0.
REQ-025 In REQ, dmem_req=1 and dmem_addr/dmem_we/dmem_be/dmem_wdata SHALL be stable until the dmem_gnt edge; outside REQ dmem_req=0.
REQ-026 Store lanes: SB wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0]; SW wdata=rs2, be=4'b1111; loads: dmem_we=0, be=4'b1111.
REQ-027 REQ with dmem_gnt: store -> IDLE, wb_valid<=1, wb_reg_write<=0, wb_exc<=0; load -> RESP.
REQ-028 RESP with dmem_rvalid: state<=IDLE, wb_valid<=1, wb_reg_write<=held reg_write, wb_rd<=held rd, wb_data<=extracted load value.
REQ-029 Load extract: select byte/half at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-030 wb_valid SHALL be a one-cycle pulse; when no retire occurs at an edge wb_valid<=0 and other wb_* hold their values.
REQ-031 dmem_gnt outside REQ and dmem_rvalid outside RESP SHALL be ignored.
REQ-032 flush SHALL NOT abort an op already in REQ or RESP; at most one retire per edge.

Reset
REQ-033 reset SHALL take priority over all other inputs at the edge: state<=IDLE, wb_valid/wb_reg_write/wb_exc<=0, wb_rd<=0, wb_data<=0, held registers<=0.
REQ-034 After reset dmem_req=0 and ex_stall=0; a reset in REQ or RESP SHALL abandon the transaction with no retire.

Verification
REQ-035 ALU op ex_result=0x12345678, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, ex_stall=0 throughout.
REQ-036 SB addr 0x00001003 rs2=0x000000AB, gnt in first REQ cycle -> dmem_addr=0x00001000, be=4'b1000, wdata=0xABABABAB, we=1; next cycle wb_valid=1, wb_reg_write=0.
REQ-037 LH addr 0x00002002, gnt after 2 REQ cycles, rvalid 3 cycles later rdata=0x8001_1234 -> wb_data=0xFFFF8001; ex_stall=1 from capture until retire edge.
REQ-038 LW addr 0x00003001 -> dmem_req never asserted; next cycle wb_valid=1, wb_exc=1, wb_reg_write=0.
REQ-039 flush=1 with ex_valid=1 LW aligned -> no dmem_req, wb_valid stays 0.
REQ-040 reset asserted in RESP, then rvalid one cycle later -> state IDLE, dmem_req=0, wb_valid=0, late rvalid ignored.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline stage with IDLE/REQ/RESP data-memory handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic        flush,
    output logic        ex_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_exc,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic        reg_write_q, reg_write_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        wb_exc_q, wb_exc_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        w_misaligned;
    logic [31:0] w_lane;
    logic [31:0] w_load_val;

    // Illegal width codes and load+store together are folded into misalignment.
    always_comb begin
        w_misaligned = 1'b0;
        if (ex_load && ex_store) begin
            w_misaligned = 1'b1;
        end else if (ex_load) begin
            case (ex_funct3)
                3'b000, 3'b100:         w_misaligned = 1'b0;
                3'b001, 3'b101:         w_misaligned = ex_result[0];
                3'b010:                 w_misaligned = |ex_result[1:0];
                default:                w_misaligned = 1'b1;
            endcase
        end else if (ex_store) begin
            case (ex_funct3)
                3'b000:                 w_misaligned = 1'b0;
                3'b001:                 w_misaligned = ex_result[0];
                3'b010:                 w_misaligned = |ex_result[1:0];
                default:                w_misaligned = 1'b1;
            endcase
        end
    end

    assign ex_stall  = (state_q != IDLE);
    assign dmem_req  = (state_q == REQ);
    assign dmem_we   = store_q;
    assign dmem_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        dmem_wdata = rs2_q;
        dmem_be    = 4'b1111;
        case (funct3_q[1:0])
            2'b00: begin
                dmem_wdata = {4{rs2_q[7:0]}};
                dmem_be    = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{rs2_q[15:0]}};
                dmem_be    = 4'b0011 << addr_q[1:0];
            end
            default: begin
                dmem_wdata = rs2_q;
                dmem_be    = 4'b1111;
            end
        endcase
        if (!store_q) begin
            dmem_be = 4'b1111;
        end
    end

    assign w_lane = dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  w_load_val = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_load_val = {24'd0, w_lane[7:0]};
            3'b001:  w_load_val = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b101:  w_load_val = {16'd0, w_lane[15:0]};
            default: w_load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        funct3_d       = funct3_q;
        store_d        = store_q;
        reg_write_d    = reg_write_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_exc_d       = wb_exc_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (!ex_load && !ex_store) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_result;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = ex_reg_write;
                        wb_exc_d       = 1'b0;
                    end else if (w_misaligned) begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_result;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = 1'b0;
                        wb_exc_d       = 1'b1;
                    end else begin
                        addr_d      = ex_result;
                        rs2_d       = ex_rs2;
                        rd_d        = ex_rd;
                        funct3_d    = ex_funct3;
                        store_d     = ex_store;
                        reg_write_d = ex_reg_write;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (store_q) begin
                        state_d        = IDLE;
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = rd_q;
                        wb_reg_write_d = 1'b0;
                        wb_exc_d       = 1'b0;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d        = IDLE;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = reg_write_q;
                    wb_rd_d        = rd_q;
                    wb_data_d      = w_load_val;
                    wb_exc_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= 32'd0;
            rs2_q          <= 32'd0;
            rd_q           <= 5'd0;
            funct3_q       <= 3'd0;
            store_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_exc_q       <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            funct3_q       <= funct3_d;
            store_q        <= store_d;
            reg_write_q    <= reg_write_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_exc_q       <= wb_exc_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_exc       = wb_exc_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

endmodule

`default_nettype wire
